// File: rtl/mips_mc_cu.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB over one shared
// memory port with a ready handshake, memory timeout, sticky trap state and retire counter.
module mips_mc_cu #(
    parameter int OPCODE_WIDTH = 6,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_mem_ready,
    input  logic                    i_trap_clr,
    output logic                    o_pc_en,
    output logic                    o_ir_en,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic                    o_mem_addr_src,
    output logic                    o_rw_en,
    output logic                    o_raddr_dst,
    output logic [1:0]              o_dsrs_out,
    output logic                    o_extend_operation,
    output logic                    o_srs_alu_b,
    output logic                    o_jmp_en,
    output logic                    o_beq_en,
    output logic                    o_bne_en,
    output logic                    o_wrong_instruction,
    output logic                    o_bus_error,
    output logic [2:0]              o_state,
    output logic [CNT_WIDTH-1:0]    o_retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE    = 4'd0,
        C_RTYPE   = 4'd1,
        C_JMP     = 4'd2,
        C_BEQ     = 4'd3,
        C_BNE     = 4'd4,
        C_ADDI    = 4'd5,
        C_SLTI    = 4'd6,
        C_ITYPE   = 4'd7,
        C_LW      = 4'd8,
        C_SW      = 4'd9,
        C_COPR    = 4'd10,
        C_ILLEGAL = 4'd11
    } class_t;

    localparam int                WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    // Opcode classification; OPCODE_WIDTH must be at least 6, wider opcodes need zero upper bits.
    function automatic class_t f_decode(input logic [5:0] op);
        class_t c;
        casez (op)
            6'b000000: c = C_RTYPE;
            6'b000010: c = C_JMP;
            6'b000100: c = C_BEQ;
            6'b000101: c = C_BNE;
            6'b001000: c = C_ADDI;
            6'b00101?: c = C_SLTI;
            6'b0011??: c = C_ITYPE;
            6'b100011: c = C_LW;
            6'b101011: c = C_SW;
            6'b010000: c = C_COPR;
            default:   c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    class_t              r_class;
    class_t              w_dec_class;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_wrong_instr;
    logic                r_bus_err;
    logic [CNT_WIDTH-1:0] r_retired;
    logic                w_retire;
    logic                w_timeout;
    logic                w_waiting;
    logic                w_imm;
    logic                w_sext;

    assign w_dec_class = ((i_opcode >> 6) != '0) ? C_ILLEGAL : f_decode(i_opcode[5:0]);
    assign w_waiting   = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
    assign w_timeout   = (MEM_TIMEOUT != 0) && w_waiting && (r_wait == WAIT_LIMIT);
    assign w_imm       = r_class inside {C_ADDI, C_SLTI, C_LW, C_SW, C_ITYPE};
    assign w_sext      = r_class inside {C_ADDI, C_SLTI, C_LW, C_SW};

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and retire strobe.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                if (i_mem_ready) begin
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                end else begin
                    w_state_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_dec_class == C_ILLEGAL) begin
                    w_state_next = S_TRAP;
                end else begin
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    C_JMP, C_BEQ, C_BNE: begin
                        w_state_next = S_FETCH;
                        w_retire     = 1'b1;
                    end
                    C_LW, C_SW:                          w_state_next = S_MEM;
                    C_RTYPE, C_ADDI, C_SLTI, C_ITYPE,
                    C_COPR:                              w_state_next = S_WB;
                    default:                             w_state_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (i_mem_ready) begin
                    if (r_class == C_SW) begin
                        w_state_next = S_FETCH;
                        w_retire     = 1'b1;
                    end else begin
                        w_state_next = S_WB;
                    end
                end else if (w_timeout) begin
                    w_state_next = S_TRAP;
                end else begin
                    w_state_next = S_MEM;
                end
            end
            S_WB: begin
                w_state_next = S_FETCH;
                w_retire     = 1'b1;
            end
            S_TRAP: begin
                if (i_trap_clr) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_TRAP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Memory wait counter: restarts on every state change, counts stalled request cycles.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait <= '0;
        end else if (w_state_next != r_state) begin
            r_wait <= '0;
        end else if (w_waiting) begin
            r_wait <= r_wait + WAIT_W'(1);
        end else begin
            r_wait <= r_wait;
        end
    end

    // Opcode class captured in DECODE; drives all later-state controls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_class <= C_NONE;
        end else if (r_state == S_DECODE) begin
            r_class <= w_dec_class;
        end else begin
            r_class <= r_class;
        end
    end

    // Sticky trap flags, released only by i_trap_clr while trapped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrong_instr <= 1'b0;
            r_bus_err     <= 1'b0;
        end else if ((r_state == S_TRAP) && i_trap_clr) begin
            r_wrong_instr <= 1'b0;
            r_bus_err     <= 1'b0;
        end else begin
            r_wrong_instr <= r_wrong_instr | ((r_state == S_DECODE) && (w_dec_class == C_ILLEGAL));
            r_bus_err     <= r_bus_err | w_timeout;
        end
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + CNT_WIDTH'(1);
        end else begin
            r_retired <= r_retired;
        end
    end

    // Datapath controls from state and latched class; FETCH enables follow ready.
    always_comb begin
        o_pc_en            = 1'b0;
        o_ir_en            = 1'b0;
        o_mem_req          = 1'b0;
        o_mem_we           = 1'b0;
        o_mem_addr_src     = 1'b0;
        o_rw_en            = 1'b0;
        o_raddr_dst        = 1'b0;
        o_dsrs_out         = 2'b00;
        o_extend_operation = 1'b0;
        o_srs_alu_b        = 1'b0;
        o_jmp_en           = 1'b0;
        o_beq_en           = 1'b0;
        o_bne_en           = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_en   = i_mem_ready;
                o_pc_en   = i_mem_ready;
            end
            S_EXEC: begin
                o_srs_alu_b        = w_imm;
                o_extend_operation = w_sext;
                o_jmp_en           = (r_class == C_JMP);
                o_pc_en            = (r_class == C_JMP);
                o_beq_en           = (r_class == C_BEQ);
                o_bne_en           = (r_class == C_BNE);
            end
            S_MEM: begin
                o_mem_req          = 1'b1;
                o_mem_addr_src     = 1'b1;
                o_extend_operation = 1'b1;
                o_srs_alu_b        = 1'b1;
                o_mem_we           = (r_class == C_SW);
            end
            S_WB: begin
                o_rw_en            = (r_class != C_COPR);
                o_raddr_dst        = (r_class == C_RTYPE);
                o_dsrs_out         = (r_class == C_LW)   ? 2'b01 :
                                     (r_class == C_COPR) ? 2'b10 : 2'b00;
                o_srs_alu_b        = w_imm;
                o_extend_operation = w_sext;
            end
            default: begin
                o_pc_en = 1'b0;
            end
        endcase
    end

    assign o_wrong_instruction = r_wrong_instr;
    assign o_bus_error         = r_bus_err;
    assign o_state             = r_state;
    assign o_retired           = r_retired;

endmodule
